// File: rtl/mux153_scan_sequencer.sv
// ============================================================================
// Module   : mux153_scan_sequencer
// Brief    : Scan controller for a 74x153 dual 4-to-1 mux. It steps the
//            select lines {b,a} through 0..3 and samples y1/y2 after a
//            settle delay. Each scan is published as two 4-bit words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux153_scan_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       cont,
    output logic       a,
    output logic       b,
    output logic       enable1,
    output logic       enable2,
    input  logic       y1,
    input  logic       y2,
    output logic [3:0] word1,
    output logic [3:0] word2,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] c_SETTLE = 4'(SETTLE_CYCLES);
    localparam bit         c_SKIP   = (SETTLE_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_sel;
    logic [3:0] r_cnt;
    logic [3:0] r_sh1;
    logic [3:0] r_sh2;
    logic [3:0] r_word1;
    logic [3:0] r_word2;
    logic       r_a;
    logic       r_b;
    logic       r_en_n;
    logic       r_busy;
    logic       r_done;

    // With zero settle time every select step is a single SAMPLE cycle.
    state_t w_step_state;
    assign w_step_state = c_SKIP ? S_SAMPLE : S_SETTLE;

    // Scan state machine; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_cnt   <= 4'd0;
            r_sh1   <= 4'd0;
            r_sh2   <= 4'd0;
            r_word1 <= 4'd0;
            r_word2 <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_en_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= w_step_state;
                        r_sel   <= 2'd0;
                        r_cnt   <= c_SETTLE;
                        r_sh1   <= 4'd0;
                        r_sh2   <= 4'd0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_en_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_en_n  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt <= 4'd1) begin
                        // Counter reaches zero on this edge.
                        r_state <= S_SAMPLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_SAMPLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_en_n  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sh1[r_sel] <= y1;
                        r_sh2[r_sel] <= y2;
                        if (r_sel != 2'd3) begin
                            r_sel      <= r_sel + 2'd1;
                            r_cnt      <= c_SETTLE;
                            r_state    <= w_step_state;
                            {r_b, r_a} <= r_sel + 2'd1;
                        end else begin
                            // Last sample goes straight into the published word
                            // so the words load on the edge entering DONE.
                            r_state <= S_DONE;
                            r_word1 <= {y1, r_sh1[2:0]};
                            r_word2 <= {y2, r_sh2[2:0]};
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                            r_en_n  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done <= 1'b0;
                    if (cont && !abort) begin
                        r_state <= w_step_state;
                        r_sel   <= 2'd0;
                        r_cnt   <= c_SETTLE;
                        r_sh1   <= 4'd0;
                        r_sh2   <= 4'd0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_en_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign enable1 = r_en_n;
    assign enable2 = r_en_n;
    assign word1   = r_word1;
    assign word2   = r_word2;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mux153_scan_sequencer.sv
// ============================================================================
// Module   : tb_mux153_scan_sequencer
// Brief    : Self-checking bench for mux153_scan_sequencer with a behavioural
//            74x153 model on each instance (default settle and zero settle).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux153_scan_sequencer;

    logic       clk;
    logic       rst;

    // Default-settle instance signals
    logic       start, abort, cont;
    logic       a, b, enable1, enable2, y1, y2, busy, done;
    logic [3:0] word1, word2;
    logic [3:0] c1, c2;

    // Zero-settle instance signals
    logic       s0_start, s0_abort, s0_cont;
    logic       s0_a, s0_b, s0_en1, s0_en2, s0_y1, s0_y2, s0_busy, s0_done;
    logic [3:0] s0_word1, s0_word2;
    logic [3:0] s0_c1, s0_c2;

    int total;
    int bad;
    int done_cnt;

    mux153_scan_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont),
        .a(a), .b(b), .enable1(enable1), .enable2(enable2),
        .y1(y1), .y2(y2), .word1(word1), .word2(word2),
        .busy(busy), .done(done)
    );

    mux153_scan_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(s0_start), .abort(s0_abort), .cont(s0_cont),
        .a(s0_a), .b(s0_b), .enable1(s0_en1), .enable2(s0_en2),
        .y1(s0_y1), .y2(s0_y2), .word1(s0_word1), .word2(s0_word2),
        .busy(s0_busy), .done(s0_done)
    );

    // 74x153 behaviour: strobe high forces Y low, else Y = C[{B,A}]
    assign y1    = enable1 ? 1'b0 : c1[{b, a}];
    assign y2    = enable2 ? 1'b0 : c2[{b, a}];
    assign s0_y1 = s0_en1 ? 1'b0 : s0_c1[{s0_b, s0_a}];
    assign s0_y2 = s0_en2 ? 1'b0 : s0_c2[{s0_b, s0_a}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic       st;
        logic       ab;
        logic       ct;
        logic [1:0] sel;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vec(input int i, input logic st, input logic ab, input logic ct,
                           input logic [1:0] sel, input logic bsy, input logic dn);
        vecs[i].st  = st;
        vecs[i].ab  = ab;
        vecs[i].ct  = ct;
        vecs[i].sel = sel;
        vecs[i].bsy = bsy;
        vecs[i].dn  = dn;
    endtask

    initial begin
        int d0;
        total = 0; bad = 0; done_cnt = 0;
        rst = 1'b1;
        start = 0; abort = 0; cont = 0;
        s0_start = 0; s0_abort = 0; s0_cont = 0;
        c1 = 4'b0110; c2 = 4'b1001;
        s0_c1 = 4'b0101; s0_c2 = 4'b1010;

        // Scan 1: 8 busy cycles with select 0,0,1,1,2,2,3,3 then DONE
        set_vec(0,  1, 0, 0, 2'd0, 1, 0);
        set_vec(1,  0, 0, 0, 2'd0, 1, 0);
        set_vec(2,  0, 0, 0, 2'd1, 1, 0);
        set_vec(3,  0, 0, 0, 2'd1, 1, 0);
        set_vec(4,  0, 0, 0, 2'd2, 1, 0);
        set_vec(5,  0, 0, 0, 2'd2, 1, 0);
        set_vec(6,  0, 0, 0, 2'd3, 1, 0);
        set_vec(7,  0, 0, 0, 2'd3, 1, 0);
        set_vec(8,  0, 0, 0, 2'd0, 0, 1);
        set_vec(9,  0, 0, 0, 2'd0, 0, 0);
        // start+abort together in IDLE: nothing starts
        set_vec(10, 1, 1, 0, 2'd0, 0, 0);
        // start held through the whole scan: ignored while busy/DONE
        set_vec(11, 1, 0, 0, 2'd0, 1, 0);
        set_vec(12, 1, 0, 0, 2'd0, 1, 0);
        set_vec(13, 1, 0, 0, 2'd1, 1, 0);
        set_vec(14, 1, 0, 0, 2'd1, 1, 0);
        set_vec(15, 1, 0, 0, 2'd2, 1, 0);
        set_vec(16, 1, 0, 0, 2'd2, 1, 0);
        set_vec(17, 1, 0, 0, 2'd3, 1, 0);
        set_vec(18, 1, 0, 0, 2'd3, 1, 0);
        set_vec(19, 0, 0, 0, 2'd0, 0, 1);
        set_vec(20, 0, 0, 0, 2'd0, 0, 0);

        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_en1", enable1, 1);
        chk("rst_en2", enable2, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_word1", word1, 0);
        chk("rst_word2", word2, 0);

        // Reset mid-scan at sel=2
        start = 1; step(); start = 0;
        step(); step(); step(); step();
        chk("pre_rst_sel", {b, a}, 2);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", {b, a}, 0);
        chk("arst_en1", enable1, 1);
        chk("arst_en2", enable2, 1);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (12) step();
        chk("arst_no_done", done_cnt, d0);
        chk("arst_word1", word1, 0);
        chk("arst_word2", word2, 0);

        // Table-driven scan sequences
        d0 = done_cnt;
        for (int i = 0; i < 21; i++) begin
            start = vecs[i].st; abort = vecs[i].ab; cont = vecs[i].ct;
            step();
            chk($sformatf("vec%0d_sel", i), {b, a}, vecs[i].sel);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].dn);
            chk($sformatf("vec%0d_en1", i), enable1, !vecs[i].bsy);
            chk($sformatf("vec%0d_en2", i), enable2, !vecs[i].bsy);
            if (i == 8 || i == 19) begin
                chk($sformatf("vec%0d_word1", i), word1, 4'b0110);
                chk($sformatf("vec%0d_word2", i), word2, 4'b1001);
            end
        end
        chk("tbl_done_count", done_cnt, d0 + 2);
        start = 0; abort = 0;

        // Abort at sel=1 of a scan with c1=1111
        c1 = 4'b1111;
        d0 = done_cnt;
        start = 1; step(); start = 0;
        step(); step();
        chk("abt_pre_sel", {b, a}, 1);
        abort = 1; step(); abort = 0;
        chk("abt_busy", busy, 0);
        chk("abt_en1", enable1, 1);
        chk("abt_sel", {b, a}, 0);
        chk("abt_word1", word1, 4'b0110);
        repeat (10) step();
        chk("abt_no_done", done_cnt, d0);
        chk("abt_word1_later", word1, 4'b0110);

        // Continuous mode: done every 9th cycle
        c1 = 4'b0001;
        cont = 1;
        start = 1; step(); start = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            chk($sformatf("cont%0d_busy", cyc), busy, (cyc != 9 && cyc != 18));
            chk($sformatf("cont%0d_done", cyc), done, (cyc == 9 || cyc == 18));
            if (cyc == 9) begin
                chk("cont_word1_a", word1, 4'b0001);
                c1 = 4'b1000;
            end
            if (cyc == 17) chk("cont_word1_hold", word1, 4'b0001);
            if (cyc == 18) begin
                chk("cont_word1_b", word1, 4'b1000);
                cont = 0;
            end
            step();
        end
        chk("cont_end_busy", busy, 0);
        chk("cont_end_done", done, 0);

        // Zero settle: 4 busy cycles then done in the 5th
        s0_start = 1; step(); s0_start = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s0_busy%0d", k), s0_busy, 1);
            chk($sformatf("s0_sel%0d", k), {s0_b, s0_a}, k);
            step();
        end
        chk("s0_done", s0_done, 1);
        chk("s0_busy_done", s0_busy, 0);
        chk("s0_word2", s0_word2, 4'b1010);
        chk("s0_word1", s0_word1, 4'b0101);
        step();
        chk("s0_done_low", s0_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux153_scan_sequencer.md
Name: mux153_scan_sequencer

Overview:
- Drives the select (a, b) and active-low strobe (g) inputs of a ttl74x153 dual 4-to-1 mux. Steps the select through all four inputs and samples y1/y2 back.
- Assembles each pair of mux outputs into two 4-bit parallel words: a parallel-to-parallel readback of both mux banks.
- Sits directly upstream (control) and downstream (capture) of the 74x153.
- One scan is started per start pulse, or scans run back-to-back in continuous mode.

Parameters:
- SETTLE_CYCLES, 1, wait cycles after each select change before sampling y1/y2. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high. Forces all state to its reset values immediately.
- start  input  1  scan request; sampled only in IDLE.
- abort  input  1  cancels an in-progress scan.
- cont  input  1  continuous mode; sampled in DONE.
- a  output  1  mux select LSB (datasheet A).
- b  output  1  mux select MSB (datasheet B).
- enable1  output  1  bank-1 strobe to the mux (g1), active low.
- enable2  output  1  bank-2 strobe to the mux (g2), active low.
- y1  input  1  mux bank-1 output.
- y2  input  1  mux bank-2 output.
- word1  output  4  last completed bank-1 scan; bit k = y1 with select {b,a}=k.
- word2  output  4  last completed bank-2 scan; same bit mapping.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse, high in DONE.

Behaviour:
- Reset values: a=0, b=0, enable1=1, enable2=1, busy=0, done=0, word1=0, word2=0. Internal state: IDLE, sel=0, wait counter=0, shadow registers=0.
- Reset mid-scan: scan is discarded immediately and no done is produced.
- Select encoding: {b,a} = sel[1:0], with a as the LSB.
- Strobe outputs: enable1 and enable2 are low only while busy; otherwise high.
- State IDLE:
  - start=1 and abort=0 -> SETTLE, with sel=0, counter=SETTLE_CYCLES, shadow registers cleared.
  - Otherwise stay in IDLE.
- State SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0 on entry (SETTLE_CYCLES=0), or reaches 0, go to SAMPLE on the next edge.
  - With SETTLE_CYCLES=0, SETTLE is skipped entirely: IDLE goes straight to SAMPLE.
- State SAMPLE:
  - On the clock edge leaving SAMPLE, shadow1[sel] <= y1 and shadow2[sel] <= y2.
  - If sel<3: sel increments, counter reloads, next state is SETTLE (or SAMPLE again if SETTLE_CYCLES=0).
  - If sel=3: go to DONE.
- State DONE (one cycle):
  - word1/word2 <= shadow registers, visible from the DONE cycle onward (loaded on the entry edge).
  - done=1, a=b=0, strobes high.
  - Next state: cont=1 -> SETTLE with a fresh scan from sel=0; cont=0 -> IDLE.
- Timing:
  - Each select step occupies SETTLE_CYCLES+1 cycles.
  - start accepted at edge N -> DONE asserted in the cycle after edge N+4*(SETTLE_CYCLES+1).
  - Default: 8 busy cycles, then done.
- Word update rule: word1/word2 update atomically, only in DONE; they never show partial scans.
- abort:
  - In SETTLE or SAMPLE: next state is IDLE, strobes high, a=b=0, words unchanged, no done.
  - In DONE: done still pulses and words still load; abort overrides cont, so next state is IDLE.
- Simultaneous start and abort in IDLE: abort wins and no scan starts.
- start while busy or in DONE: ignored, not queued.
- sel wraps only by restarting at 0 on a new scan; it never counts past 3.

Test Plan:
- Default params, mux c1=4'b0110, c2=4'b1001 (bit k = input k), 1-cycle start -> busy for 8 cycles; {b,a} sequence 0,0,1,1,2,2,3,3; done pulses once; word1=4'b0110, word2=4'b1001.
- Assert rst while sel=2 mid-scan -> immediately a=b=0, enable1=enable2=1, busy=0; words keep reset value 0; no done afterwards.
- After a completed scan with word1=4'b0110, assert abort at sel=1 of a second scan with c1=4'b1111 -> next cycle IDLE, strobes high, word1 still 4'b0110, no done pulse.
- cont=1 held, c1 changed from 4'b0001 to 4'b1000 between scans -> done pulses every 9th cycle (8 busy + 1 done); word1 reads 4'b0001 then 4'b1000; busy low only during DONE cycles.
- SETTLE_CYCLES=0, c2=4'b1010 -> 4 busy cycles with {b,a}=0,1,2,3; word2=4'b1010; done in the 5th cycle after start acceptance.
- start and abort high together in IDLE -> remains IDLE, busy=0; start pulsed while busy -> ignored, exactly one done pulse.
